// File: rtl/io_post_ctrl.sv
// IO post-write controller: accepts posted and non-posted IO cycles,
// sequences IOREQ/IOACK/IOREADY with the IO engine, and drives DTACK-side readies.
module io_post_ctrl (
    input  logic FCLK,
    input  logic nRES,
    input  logic BACT,
    input  logic IOCS,
    input  logic IOPWCS,
    input  logic IOACK,
    input  logic IOREADY,
    output logic PWLatch,
    output logic IOREQ,
    output logic IOPWReady,
    output logic IONPReady,
    output logic PWFull
);

    typedef enum logic [2:0] {
        IDLE,
        PWBUSY,
        NPWAIT,
        NPREQ,
        NPBUSY,
        NPDONE
    } state_t;

    state_t state, state_n;
    logic   served, served_n;
    logic   pw_req, np_req, acc_pw, acc_np;
    logic   pwlatch_n, ioreq_n, iopwready_n, ionpready_n, pwfull_n;

    assign pw_req = BACT & IOCS & IOPWCS & ~served;
    assign np_req = BACT & IOCS & ~IOPWCS & ~served;
    assign acc_pw = (state == IDLE) & pw_req;
    assign acc_np = ((state == IDLE) | (state == PWBUSY)) & np_req;

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            state     <= IDLE;
            served    <= 1'b0;
            PWLatch   <= 1'b0;
            IOREQ     <= 1'b0;
            IOPWReady <= 1'b0;
            IONPReady <= 1'b0;
            PWFull    <= 1'b0;
        end else begin
            state     <= state_n;
            served    <= served_n;
            PWLatch   <= pwlatch_n;
            IOREQ     <= ioreq_n;
            IOPWReady <= iopwready_n;
            IONPReady <= ionpready_n;
            PWFull    <= pwfull_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (pw_req)      state_n = PWBUSY;
                else if (np_req) state_n = NPREQ;
            end
            // A drain coinciding with a non-posted request skips the wait state
            PWBUSY: begin
                if (np_req)       state_n = IOREADY ? NPREQ : NPWAIT;
                else if (IOREADY) state_n = IDLE;
            end
            NPWAIT: if (IOREADY) state_n = NPREQ;
            NPREQ: begin
                if (IOACK & IOREADY) state_n = NPDONE;
                else if (IOACK)      state_n = NPBUSY;
            end
            NPBUSY: if (IOREADY) state_n = NPDONE;
            NPDONE: if (!(BACT & served)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pwlatch_n   = acc_pw;
        iopwready_n = BACT & (IOPWReady | acc_pw);
        served_n    = BACT & (served | acc_pw | acc_np);
        ioreq_n     = IOREQ & ~IOACK;
        pwfull_n    = PWFull;
        ionpready_n = 1'b0;
        unique case (state)
            IDLE: begin
                ioreq_n  = acc_pw | acc_np;
                pwfull_n = acc_pw;
            end
            PWBUSY: begin
                if (IOREADY) begin
                    pwfull_n = 1'b0;
                    ioreq_n  = np_req;
                end
            end
            NPWAIT: begin
                if (IOREADY) begin
                    pwfull_n = 1'b0;
                    ioreq_n  = 1'b1;
                end
            end
            NPREQ:  ionpready_n = IOACK & IOREADY;
            NPBUSY: ionpready_n = IOREADY;
            // Served drops with BACT, so an abandoned cycle gets a one-cycle pulse
            NPDONE: ionpready_n = BACT & served;
            default: ionpready_n = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_io_post_ctrl.sv
// Directed bench for io_post_ctrl; expected output vectors are queued
// with each stimulus step and popped when the DUT output is sampled.
module tb_io_post_ctrl;

    logic FCLK, nRES, BACT, IOCS, IOPWCS, IOACK, IOREADY;
    logic PWLatch, IOREQ, IOPWReady, IONPReady, PWFull;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    // input vector {BACT,IOCS,IOPWCS,IOACK,IOREADY}
    localparam logic [4:0] I0  = 5'b00000;
    localparam logic [4:0] PW  = 5'b11100;
    localparam logic [4:0] NP  = 5'b11000;
    localparam logic [4:0] ACK = 5'b00010;
    localparam logic [4:0] RDY = 5'b00001;

    io_post_ctrl dut (
        .FCLK(FCLK),
        .nRES(nRES),
        .BACT(BACT),
        .IOCS(IOCS),
        .IOPWCS(IOPWCS),
        .IOACK(IOACK),
        .IOREADY(IOREADY),
        .PWLatch(PWLatch),
        .IOREQ(IOREQ),
        .IOPWReady(IOPWReady),
        .IONPReady(IONPReady),
        .PWFull(PWFull)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // observed vector {PWLatch,IOREQ,IOPWReady,IONPReady,PWFull}
    task automatic check();
        logic [4:0] e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {PWLatch, IOREQ, IOPWReady, IONPReady, PWFull};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
    endtask

    task automatic cyc(input logic [4:0] in, input logic [4:0] e, input string t);
        {BACT, IOCS, IOPWCS, IOACK, IOREADY} = in;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge FCLK);
        #1;
        check();
    endtask

    task automatic rst_pulse(input string t);
        nRES = 1'b0;
        exp_q.push_back(5'b00000);
        tag_q.push_back(t);
        #2;
        check();
        {BACT, IOCS, IOPWCS, IOACK, IOREADY} = I0;
        #1;
        nRES = 1'b1;
    endtask

    initial begin
        nRES = 1'b0;
        {BACT, IOCS, IOPWCS, IOACK, IOREADY} = I0;
        #1;
        exp_q.push_back(5'b00000);
        tag_q.push_back("reset");
        check();
        repeat (2) @(posedge FCLK);
        #1;
        nRES = 1'b1;

        // single posted write
        cyc(PW,  5'b11101, "pw_accept");
        cyc(PW,  5'b01101, "pw_hold");
        cyc(I0,  5'b01001, "pw_bact_low");
        cyc(ACK, 5'b00001, "pw_ack");
        cyc(I0,  5'b00001, "pw_busy");
        cyc(RDY, 5'b00000, "pw_drain");

        // held cycle: only one latch pulse
        cyc(PW, 5'b11101, "held_0");
        cyc(PW, 5'b01101, "held_1");
        cyc(PW | ACK, 5'b00101, "held_2");
        for (int i = 3; i < 10; i++) cyc(PW, 5'b00101, $sformatf("held_%0d", i));
        cyc(RDY, 5'b00000, "held_end");

        // back-to-back posts
        cyc(PW, 5'b11101, "b2b_first");
        cyc(I0, 5'b01001, "b2b_gap");
        cyc(PW, 5'b01001, "b2b_full");
        cyc(PW | ACK, 5'b00001, "b2b_ack");
        cyc(PW, 5'b00001, "b2b_wait");
        cyc(PW | RDY, 5'b00000, "b2b_drain");
        cyc(PW, 5'b11101, "b2b_second");
        cyc(ACK | RDY, 5'b00000, "b2b_single");

        // non-posted behind post
        cyc(PW,  5'b11101, "np_post");
        cyc(ACK, 5'b00001, "np_post_ack");
        cyc(NP,  5'b00001, "np_wait");
        cyc(NP,  5'b00001, "np_wait2");
        cyc(NP | RDY, 5'b01000, "np_req");
        cyc(NP,  5'b01000, "np_req_hold");
        cyc(NP | ACK, 5'b00000, "np_ack");
        cyc(NP,  5'b00000, "np_busy");
        cyc(NP | RDY, 5'b00010, "np_done");
        cyc(NP,  5'b00010, "np_done_hold");
        cyc(I0,  5'b00000, "np_release");
        cyc(I0,  5'b00000, "np_idle");

        // single-cycle engine, BACT held
        cyc(NP, 5'b01000, "sc_req");
        cyc(NP | ACK | RDY, 5'b00010, "sc_done_0");
        for (int i = 1; i < 5; i++) cyc(NP, 5'b00010, $sformatf("sc_done_%0d", i));
        cyc(I0, 5'b00000, "sc_release");

        // BACT falls mid-access: one-cycle completion pulse
        cyc(NP,  5'b01000, "ab_req");
        cyc(I0,  5'b01000, "ab_bact_low");
        cyc(ACK, 5'b00000, "ab_ack");
        cyc(NP,  5'b00000, "ab_new_cycle");
        cyc(NP | RDY, 5'b00010, "ab_pulse");
        cyc(NP,  5'b00000, "ab_pulse_end");
        cyc(NP,  5'b01000, "ab_new_accept");
        cyc(ACK | RDY, 5'b00010, "ab_done");
        cyc(I0,  5'b00000, "ab_idle");

        // stray IOREADY and non-IO cycles
        cyc(RDY, 5'b00000, "stray_ready");
        cyc(5'b10100, 5'b00000, "non_io");
        cyc(I0,  5'b00000, "non_io_end");

        // reset mid-post
        cyc(PW, 5'b11101, "rp_accept");
        cyc(PW, 5'b01101, "rp_hold");
        rst_pulse("rp_reset");
        cyc(RDY, 5'b00000, "rp_ready");
        cyc(I0,  5'b00000, "rp_no_req");

        // reset mid-NPBUSY
        cyc(NP, 5'b01000, "rn_req");
        cyc(NP | ACK, 5'b00000, "rn_busy");
        rst_pulse("rn_reset");
        cyc(RDY, 5'b00000, "rn_ready");
        cyc(I0,  5'b00000, "rn_idle");
        cyc(PW,  5'b11101, "rn_first_accept");
        cyc(ACK | RDY, 5'b00000, "rn_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
